// File: rtl/rv32i_ifetch_prefetch.sv
// rv32i_ifetch_prefetch: sequential instruction prefetch queue between
// the core fetch port and a pipelined, in-order Avalon-MM memory.
module rv32i_ifetch_prefetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0,
    parameter int          DEPTH        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iaddress,
    input  logic        iread,
    output logic [31:0] ireaddata,
    output logic        iwaitrequest,
    output logic [31:0] m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;

    logic [31:0]   q [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [31:0]   head_addr;
    logic [31:0]   fetch_addr;

    logic          match;
    logic          hit;
    logic          flush;
    logic          accept;
    logic          pend;
    logic          resp;
    logic          push;
    logic          pop;
    logic          issue_ok;
    logic [CW-1:0] count_n;
    logic [CW-1:0] inflight_n;
    logic [SW-1:0] credit;
    logic [31:0]   base;

    assign match  = iread && (iaddress == head_addr);
    assign hit    = match && (count != '0) && !reset;
    assign flush  = iread && !match;
    assign accept = m_read && !m_waitrequest;
    assign pend   = m_read && m_waitrequest;
    assign resp   = m_readdatavalid;
    // A response landing in a flush cycle belongs to the old stream.
    assign push   = resp && (drop == '0) && !flush;
    assign pop    = hit;

    assign iwaitrequest = !hit;
    assign ireaddata    = hit ? q[rd_ptr] : 32'h0;

    always_comb begin
        count_n = count;
        if (flush)
            count_n = '0;
        else if (push && !pop)
            count_n = count + CW'(1);
        else if (pop && !push)
            count_n = count - CW'(1);
    end

    always_comb begin
        inflight_n = inflight;
        if (accept && !resp)
            inflight_n = inflight + CW'(1);
        else if (resp && !accept)
            inflight_n = inflight - CW'(1);
    end

    // Stale reads still occupy credits until their responses drain.
    assign credit   = {1'b0, count_n} + {1'b0, inflight_n};
    assign issue_ok = credit < SW'(DEPTH);
    assign base     = flush ? iaddress : fetch_addr;

    always_ff @(posedge clk) begin
        if (push)
            q[wr_ptr] <= m_readdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            inflight   <= '0;
            drop       <= '0;
            head_addr  <= RESET_VECTOR;
            fetch_addr <= RESET_VECTOR;
            m_read     <= 1'b0;
            m_address  <= RESET_VECTOR;
        end else begin
            count    <= count_n;
            inflight <= inflight_n;
            if (flush) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                head_addr <= iaddress;
                // Everything outstanding, plus a stalled request, is stale.
                drop      <= inflight_n + CW'(pend);
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop) begin
                    rd_ptr    <= rd_ptr + AW'(1);
                    head_addr <= head_addr + 32'd4;
                end
                if (resp && drop != '0)
                    drop <= drop - CW'(1);
            end
            if (pend) begin
                fetch_addr <= base;
            end else begin
                m_read <= issue_ok;
                if (issue_ok) begin
                    m_address  <= base;
                    fetch_addr <= base + 32'd4;
                end else begin
                    fetch_addr <= base;
                end
            end
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && count == CW'(DEPTH)));

endmodule
